// File: rtl/jpeg_stream_parser.sv
// jpeg_stream_parser
//   Receive-side JPEG byte-stream parser. Follows the SOI / marker segment /
//   SOS / EOI structure, captures the picture size from SOF0 and forwards the
//   de-stuffed entropy-coded scan bytes.
// Ports
//   clk, rstn          clock, synchronous active-low reset
//   data_valid_i       byte strobe (no backpressure)
//   data_i             input byte
//   frame_start        pulse, SOI accepted (also on an in-frame SOI restart)
//   sof_valid          pulse, pic_height/pic_width updated from SOF0
//   pic_height/width   SOF0 Y/X fields, held between sof_valid pulses
//   scan_valid         de-stuffed scan byte strobe
//   scan_data          de-stuffed scan byte, held while scan_valid=0
//   scan_byte_cnt      scan bytes emitted this frame, saturating
//   frame_done         pulse, EOI accepted inside a frame
//   err_marker         pulse, protocol error
module jpeg_stream_parser #(
    parameter int unsigned W_DIM  = 16,
    parameter int unsigned W_BCNT = 24
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              data_valid_i,
    input  logic [7:0]        data_i,
    output logic              frame_start,
    output logic              sof_valid,
    output logic [W_DIM-1:0]  pic_height,
    output logic [W_DIM-1:0]  pic_width,
    output logic              scan_valid,
    output logic [7:0]        scan_data,
    output logic [W_BCNT-1:0] scan_byte_cnt,
    output logic              frame_done,
    output logic              err_marker
);

    typedef enum logic [2:0] {
        S_IDLE, S_SOI_FF, S_MARK, S_LEN_H, S_LEN_L, S_SEG, S_SCAN, S_SCAN_FF
    } state_e;

    state_e      state_q, state_d;
    logic        mark_ff_q, mark_ff_d;      // MARK: leading FF already seen
    logic [7:0]  code_q, code_d;
    logic [7:0]  len_h_q, len_h_d;
    logic [15:0] rem_q, rem_d;
    logic [2:0]  bidx_q, bidx_d;            // segment body byte index, saturating
    logic        sof_ok_q, sof_ok_d;        // L >= 7
    logic [15:0] hgt_q, hgt_d, wid_q, wid_d; // SOF0 shadow, published on sof_valid

    logic        ev_start, ev_sof, ev_emit, ev_done, ev_err, seg_end;
    logic [7:0]  emit_byte;
    logic [15:0] len_full;

    logic              frame_start_q, frame_start_d;
    logic              sof_valid_q, sof_valid_d;
    logic [W_DIM-1:0]  pic_height_q, pic_height_d, pic_width_q, pic_width_d;
    logic              scan_valid_q, scan_valid_d;
    logic [7:0]        scan_data_q, scan_data_d;
    logic [W_BCNT-1:0] cnt_q, cnt_d;
    logic              frame_done_q, frame_done_d;
    logic              err_marker_q, err_marker_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            mark_ff_q     <= 1'b0;
            code_q        <= '0;
            len_h_q       <= '0;
            rem_q         <= '0;
            bidx_q        <= '0;
            sof_ok_q      <= 1'b0;
            hgt_q         <= '0;
            wid_q         <= '0;
            frame_start_q <= 1'b0;
            sof_valid_q   <= 1'b0;
            pic_height_q  <= '0;
            pic_width_q   <= '0;
            scan_valid_q  <= 1'b0;
            scan_data_q   <= '0;
            cnt_q         <= '0;
            frame_done_q  <= 1'b0;
            err_marker_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            mark_ff_q     <= mark_ff_d;
            code_q        <= code_d;
            len_h_q       <= len_h_d;
            rem_q         <= rem_d;
            bidx_q        <= bidx_d;
            sof_ok_q      <= sof_ok_d;
            hgt_q         <= hgt_d;
            wid_q         <= wid_d;
            frame_start_q <= frame_start_d;
            sof_valid_q   <= sof_valid_d;
            pic_height_q  <= pic_height_d;
            pic_width_q   <= pic_width_d;
            scan_valid_q  <= scan_valid_d;
            scan_data_q   <= scan_data_d;
            cnt_q         <= cnt_d;
            frame_done_q  <= frame_done_d;
            err_marker_q  <= err_marker_d;
        end
    end

    // Next-state and event decode
    always_comb begin
        state_d   = state_q;
        mark_ff_d = mark_ff_q;
        code_d    = code_q;
        len_h_d   = len_h_q;
        rem_d     = rem_q;
        bidx_d    = bidx_q;
        sof_ok_d  = sof_ok_q;
        hgt_d     = hgt_q;
        wid_d     = wid_q;
        ev_start  = 1'b0;
        ev_sof    = 1'b0;
        ev_emit   = 1'b0;
        ev_done   = 1'b0;
        ev_err    = 1'b0;
        seg_end   = 1'b0;
        emit_byte = data_i;
        len_full  = {len_h_q, data_i};

        if (data_valid_i) begin
            unique case (state_q)
                S_IDLE: if (data_i == 8'hFF) state_d = S_SOI_FF;
                S_SOI_FF: begin
                    if (data_i == 8'hD8) begin
                        ev_start  = 1'b1;
                        mark_ff_d = 1'b0;
                        state_d   = S_MARK;
                    end else if (data_i != 8'hFF) begin
                        state_d = S_IDLE;
                    end
                end
                S_MARK: begin
                    if (!mark_ff_q) begin
                        if (data_i == 8'hFF) mark_ff_d = 1'b1;
                        else begin
                            ev_err  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else if (data_i == 8'hD8) begin
                        ev_err    = 1'b1;
                        ev_start  = 1'b1;
                        mark_ff_d = 1'b0;
                    end else if (data_i == 8'hD9) begin
                        ev_done = 1'b1;
                        state_d = S_IDLE;
                    end else if (data_i != 8'hFF) begin
                        code_d  = data_i;
                        state_d = S_LEN_H;
                    end
                end
                S_LEN_H: begin
                    len_h_d = data_i;
                    state_d = S_LEN_L;
                end
                S_LEN_L: begin
                    if (len_full < 16'd2) begin
                        ev_err  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rem_d    = len_full - 16'd2;
                        bidx_d   = '0;
                        sof_ok_d = (len_full >= 16'd7);
                        if (len_full == 16'd2) seg_end = 1'b1;
                        else                   state_d = S_SEG;
                    end
                end
                S_SEG: begin
                    // Body byte 0 is the sample precision; 1-2 height, 3-4 width.
                    if (code_q == 8'hC0) begin
                        case (bidx_q)
                            3'd1:    hgt_d[15:8] = data_i;
                            3'd2:    hgt_d[7:0]  = data_i;
                            3'd3:    wid_d[15:8] = data_i;
                            3'd4:    wid_d[7:0]  = data_i;
                            default: ;
                        endcase
                    end
                    if (bidx_q != 3'd7) bidx_d = bidx_q + 3'd1;
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) seg_end = 1'b1;
                end
                S_SCAN: begin
                    if (data_i == 8'hFF) state_d = S_SCAN_FF;
                    else                 ev_emit = 1'b1;
                end
                S_SCAN_FF: begin
                    if (data_i == 8'h00) begin
                        ev_emit   = 1'b1;
                        emit_byte = 8'hFF;
                        state_d   = S_SCAN;
                    end else if (data_i == 8'hD9) begin
                        ev_done = 1'b1;
                        state_d = S_IDLE;
                    end else if (data_i[7:3] == 5'b11010) begin
                        state_d = S_SCAN;
                    end else if (data_i == 8'hD8) begin
                        // SOI inside a scan aborts the frame and starts a new one.
                        ev_err    = 1'b1;
                        ev_start  = 1'b1;
                        mark_ff_d = 1'b0;
                        state_d   = S_MARK;
                    end else if (data_i != 8'hFF) begin
                        ev_err  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (seg_end) begin
            if (code_q == 8'hC0 && !sof_ok_d) begin
                ev_err  = 1'b1;
                state_d = S_IDLE;
            end else begin
                ev_sof    = (code_q == 8'hC0);
                mark_ff_d = 1'b0;
                state_d   = (code_q == 8'hDA) ? S_SCAN : S_MARK;
            end
        end
    end

    // Output decode
    always_comb begin
        frame_start_d = ev_start;
        sof_valid_d   = ev_sof;
        frame_done_d  = ev_done;
        err_marker_d  = ev_err;
        scan_valid_d  = ev_emit;
        scan_data_d   = ev_emit ? emit_byte : scan_data_q;
        pic_height_d  = ev_sof ? W_DIM'(hgt_q) : pic_height_q;
        pic_width_d   = ev_sof ? W_DIM'(wid_q) : pic_width_q;
        cnt_d         = cnt_q;
        if (ev_start)                  cnt_d = '0;
        else if (ev_emit && cnt_q != '1) cnt_d = cnt_q + W_BCNT'(1);
    end

    assign frame_start   = frame_start_q;
    assign sof_valid     = sof_valid_q;
    assign pic_height    = pic_height_q;
    assign pic_width     = pic_width_q;
    assign scan_valid    = scan_valid_q;
    assign scan_data     = scan_data_q;
    assign scan_byte_cnt = cnt_q;
    assign frame_done    = frame_done_q;
    assign err_marker    = err_marker_q;

endmodule
